// File: rtl/burst_ca_pkg.sv
// burst_ca_pkg: shared state type and width helpers for the burst cacheline adaptor
package burst_ca_pkg;
   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} ca_state_e;
   function automatic int beats_f(int line_w, int bus_w);
      return line_w / bus_w;
   endfunction
   function automatic int cnt_w_f(int line_w, int bus_w);
      return $clog2(beats_f(line_w, bus_w));
   endfunction
   function automatic int ofs_w_f(int line_w);
      return $clog2(line_w / 8);
   endfunction
   function automatic int bofs_w_f(int bus_w);
      return $clog2(bus_w / 8);
   endfunction
   function automatic bit cfg_ok_f(int line_w, int bus_w);
      int b = beats_f(line_w, bus_w);
      return (bus_w % 8 == 0) && (line_w % bus_w == 0) && (b >= 2) && ((b & (b - 1)) == 0);
   endfunction
endpackage

// File: rtl/burst_cacheline_adaptor_if.sv
// burst_ca_if: cache-side line bus and memory-side beat bus of the adaptor
interface burst_ca_if #(parameter int LINE_W = 256, parameter int BUS_W = 32, parameter int ADDR_W = 32);
   logic              ca_read;
   logic              ca_write;
   logic [ADDR_W-1:0] ca_addr;
   logic [LINE_W-1:0] ca_wdata;
   logic [LINE_W-1:0] ca_rdata;
   logic              ca_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [BUS_W-1:0]  pmem_wdata;
   logic [BUS_W-1:0]  pmem_rdata;
   logic              pmem_resp;
   modport slave (input ca_read, ca_write, ca_addr, ca_wdata, pmem_rdata, pmem_resp,
                  output ca_rdata, ca_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata);
   modport master (output ca_read, ca_write, ca_addr, ca_wdata, pmem_rdata, pmem_resp,
                   input ca_rdata, ca_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata);
endinterface

// File: rtl/burst_ca_beat_ctr.sv
// burst_ca_beat_ctr: beat counter; idx is the start beat offset by the count, modulo BEATS
module burst_ca_beat_ctr #(parameter int CNT_W = 3) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic [CNT_W-1:0] i_start,
   input  logic             i_adv,
   output logic [CNT_W-1:0] o_idx,
   output logic             o_last
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= i_clear ? '0 : i_adv ? r_cnt + 1'b1 : r_cnt;
   assign o_idx  = i_start + r_cnt;
   assign o_last = &r_cnt;
endmodule

// File: rtl/burst_cacheline_adaptor.sv
// burst_cacheline_adaptor: line <-> beat burst adaptor between L1 cache and memory.
// Define CA_WRAP_BURST_EN for critical-word-first wrap-around read bursts.
module burst_cacheline_adaptor
   import burst_ca_pkg::*;
#(
   parameter int LINE_W = 256,
   parameter int BUS_W  = 32,
   parameter int ADDR_W = 32
) (
   input logic      clk,
   input logic      rst_n,
   burst_ca_if.slave bus
);
   localparam int OFS_W  = ofs_w_f(LINE_W);
   localparam int BOFS_W = bofs_w_f(BUS_W);
   localparam int CNT_W  = cnt_w_f(LINE_W, BUS_W);
   if (!cfg_ok_f(LINE_W, BUS_W)) begin : g_bad_cfg
      $error("burst_cacheline_adaptor: LINE_W/BUS_W must be a power of two >= 2");
   end
   ca_state_e         r_state, w_next;
   logic [ADDR_W-1:0] r_base;
   logic [LINE_W-1:0] r_line, r_rdata;
   logic [CNT_W-1:0]  r_start, w_idx;
   logic              w_last, w_busy, w_beat, w_unused;
   assign w_busy   = (r_state == RD_BURST) || (r_state == WR_BURST);
   assign w_beat   = w_busy && bus.pmem_resp;
   assign w_unused = ^bus.ca_addr[OFS_W-1:0];
   burst_ca_beat_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clear(r_state == IDLE),
      .i_start(r_start),
      .i_adv  (w_beat),
      .o_idx  (w_idx),
      .o_last (w_last)
   );
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:     w_next = bus.ca_read ? RD_BURST : bus.ca_write ? WR_BURST : IDLE;
         RD_BURST,
         WR_BURST: w_next = (w_beat && w_last) ? DONE : r_state;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_base  <= '0;
         r_line  <= '0;
         r_rdata <= '0;
         r_start <= '0;
      end else begin
         if (r_state == IDLE && (bus.ca_read || bus.ca_write)) begin
            r_base <= {bus.ca_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
`ifdef CA_WRAP_BURST_EN
            r_start <= bus.ca_read ? bus.ca_addr[OFS_W-1:BOFS_W] : '0;
`else
            r_start <= '0;
`endif
            if (!bus.ca_read) r_line <= bus.ca_wdata;
         end
         if (w_beat && r_state == RD_BURST) r_rdata[int'(w_idx)*BUS_W +: BUS_W] <= bus.pmem_rdata;
      end
   assign bus.ca_rdata   = r_rdata;
   assign bus.ca_resp    = (r_state == DONE);
   assign bus.pmem_read  = (r_state == RD_BURST);
   assign bus.pmem_write = (r_state == WR_BURST);
   assign bus.pmem_addr  = w_busy ? r_base + (ADDR_W'(w_idx) << BOFS_W) : '0;
   assign bus.pmem_wdata = (r_state == WR_BURST) ? r_line[int'(w_idx)*BUS_W +: BUS_W] : '0;
endmodule

// File: tb/tb_burst_cacheline_adaptor.sv
// tb_burst_cacheline_adaptor: random and directed bursts against a line-level reference model
module tb_burst_cacheline_adaptor;
`ifdef CA_WRAP_BURST_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   logic [31:0]  mem_w [8];
   logic [255:0] exp_rdata = '0;
   always #5 clk = ~clk;
   burst_ca_if #(.LINE_W(256), .BUS_W(32), .ADDR_W(32)) bus ();
   burst_cacheline_adaptor #(.LINE_W(256), .BUS_W(32), .ADDR_W(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic check_quiet(input string tag);
      check({tag, "_resp"}, bus.ca_resp, 0);
      check({tag, "_rd"}, bus.pmem_read, 0);
      check({tag, "_wr"}, bus.pmem_write, 0);
      check({tag, "_addr"}, bus.pmem_addr, 0);
      check({tag, "_wdata"}, bus.pmem_wdata, 0);
   endtask
   // One line transaction; rst_at >= 0 pulses reset once that many beats are done.
   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] wline,
                          input int wlo, input int whi, input int rst_at);
      bit er = rd;
      bit ew = !rd && wr;
      int s = (WRAP && er) ? int'(addr[4:2]) : 0;
      logic [31:0] base = addr & ~32'h1F;
      int k = 0;
      int waitc = $urandom_range(wlo, whi);
      bit done = 1'b0;
      logic [255:0] line = '0;
      for (int i = 0; i < 8; i++) line[i*32 +: 32] = mem_w[i];
      @(negedge clk);
      bus.ca_read = rd; bus.ca_write = wr; bus.ca_addr = addr; bus.ca_wdata = wline; bus.pmem_resp = 0;
      for (int cyc = 1; cyc < 300 && !done; cyc++) begin
         @(posedge clk); #1;
         if (k == rst_at) begin
            rst_n = 1'b0; #1;
            check_quiet("rst");
            check("rst_rdata", bus.ca_rdata, 0);
            exp_rdata = '0;
            bus.ca_read = 0; bus.ca_write = 0; bus.pmem_resp = 0;
            @(negedge clk); rst_n = 1'b1;
            return;
         end
         if (k == 8) begin
            check("resp", bus.ca_resp, 1);
            check("done_rd", bus.pmem_read, 0);
            check("done_wr", bus.pmem_write, 0);
            if (er) exp_rdata = line;
            check("rdata", bus.ca_rdata, exp_rdata);
            if (whi == 0) check("latency", cyc, 9);
            bus.ca_read = 0; bus.ca_write = 0; bus.pmem_resp = 1'($urandom);
            done = 1'b1;
         end else begin
            check("busy_resp", bus.ca_resp, 0);
            check("pmem_read", bus.pmem_read, er);
            check("pmem_write", bus.pmem_write, ew);
            check("pmem_addr", bus.pmem_addr, base + 32'(((s + k) % 8) * 4));
            if (ew) check("pmem_wdata", bus.pmem_wdata, wline[((s + k) % 8)*32 +: 32]);
            if (cyc > 1) bus.ca_addr = $urandom;
            if (cyc > 1) bus.ca_wdata = {8{$urandom}};
            if (waitc == 0) begin
               bus.pmem_resp = 1; bus.pmem_rdata = mem_w[(s + k) % 8];
               k++; waitc = $urandom_range(wlo, whi);
            end else begin
               bus.pmem_resp = 0; bus.pmem_rdata = $urandom; waitc--;
            end
         end
      end
      if (!done) check("timeout", 0, 1);
      @(posedge clk); #1;
      check_quiet("after");
      bus.pmem_resp = 0;
   endtask
   initial begin
      logic [255:0] wl;
      bus.ca_read = 0; bus.ca_write = 0; bus.ca_addr = 0; bus.ca_wdata = 0;
      bus.pmem_rdata = 0; bus.pmem_resp = 0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      check("reset_rdata", bus.ca_rdata, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_quiet("idle");
         bus.pmem_resp = 1'($urandom);
      end
      bus.pmem_resp = 0;
      for (int i = 0; i < 8; i++) mem_w[i] = 32'hA0 + i;
      run_txn(1, 0, 32'h1000, '0, 0, 0, -1);
      for (int i = 0; i < 8; i++) wl[i*32 +: 32] = 32'hB0 + i;
      run_txn(0, 1, 32'h2020, wl, 2, 2, -1);
      for (int i = 0; i < 8; i++) mem_w[i] = $urandom;
      run_txn(1, 1, 32'h3000, wl, 0, 1, -1);
      run_txn(1, 0, 32'h4000, '0, 0, 1, 4);
      for (int i = 0; i < 8; i++) mem_w[i] = $urandom;
      run_txn(1, 0, 32'h4000, '0, 0, 0, -1);
      for (int i = 0; i < 8; i++) mem_w[i] = 32'hC0 + i;
      run_txn(1, 0, 32'h1014, '0, 0, 0, -1);
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 8; i++) mem_w[i] = $urandom;
         for (int i = 0; i < 8; i++) wl[i*32 +: 32] = $urandom;
         run_txn(1'($urandom), 1'b1, $urandom, wl, 0, 3, -1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
